// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RISC-V size/sign funct3 codes and fault cause encodings.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: builds byte strobes and replicated store data,
// extracts and extends load data, and flags illegal or misaligned accesses.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;

  always_comb begin
    wstrb      = 4'b0000;
    wdata      = '0;
    rdata_ext  = '0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    shifted    = rdata_raw >> {offset, 3'b000};

    if (we) begin
      case (funct3)
        F3_B: begin
          wstrb = 4'b0001 << offset;
          wdata = {4{wdata_in[7:0]}};
        end
        F3_H: begin
          wstrb = 4'b0011 << offset;
          wdata = {2{wdata_in[15:0]}};
        end
        F3_W: begin
          wstrb = 4'b1111;
          wdata = wdata_in;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
        F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
        F3_W:    rdata_ext = shifted;
        F3_BU:   rdata_ext = {24'd0, shifted[7:0]};
        F3_HU:   rdata_ext = {16'd0, shifted[15:0]};
        default: illegal = 1'b1;
      endcase
    end

    // Illegal codes take priority, so only legal sizes are alignment-checked.
    if (!illegal) begin
      case (funct3)
        F3_H, F3_HU: misaligned = offset[0];
        F3_W:        misaligned = (offset != 2'b00);
        default:     misaligned = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Turns datapath loads/stores into word-aligned valid/ready bus transactions,
// stalling the core until each access completes, faults or times out.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  lsu_state_t      state, state_next;
  logic [7:0]      cnt, cnt_next;
  logic [1:0]      cause_q, cause_next;
  logic [2:0]      f3_q, f3_next;
  logic [1:0]      off_q, off_next;
  logic            we_next;
  logic [XLEN-1:0] addr_next, wdata_next, rdata_next;
  logic [3:0]      wstrb_next;

  logic [2:0]      align_f3;
  logic [1:0]      align_off;
  logic            align_we;
  logic [3:0]      align_wstrb;
  logic [XLEN-1:0] align_wdata, align_rdata;
  logic            align_misaligned, align_illegal;

  // Decode live request fields while idle, latched fields once on the bus.
  assign align_f3  = (state == IDLE) ? req_funct3    : f3_q;
  assign align_off = (state == IDLE) ? req_addr[1:0] : off_q;
  assign align_we  = (state == IDLE) ? req_we        : mem_we;

  lsu_align u_align (
    .we         (align_we),
    .funct3     (align_f3),
    .offset     (align_off),
    .wdata_in   (req_wdata),
    .rdata_raw  (mem_rdata),
    .wstrb      (align_wstrb),
    .wdata      (align_wdata),
    .rdata_ext  (align_rdata),
    .misaligned (align_misaligned),
    .illegal    (align_illegal)
  );

  assign stall       = req_valid && (state != DONE);
  assign mem_valid   = (state == BUS);
  assign done        = (state == DONE);
  assign fault_cause = (state == DONE) ? cause_q : CAUSE_NONE;
  assign fault       = (state == DONE) && (cause_q != CAUSE_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cause_q   <= CAUSE_NONE;
      f3_q      <= '0;
      off_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cause_q   <= cause_next;
      f3_q      <= f3_next;
      off_q     <= off_next;
      mem_we    <= we_next;
      mem_addr  <= addr_next;
      mem_wstrb <= wstrb_next;
      mem_wdata <= wdata_next;
      rdata     <= rdata_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cause_next = cause_q;
    f3_next    = f3_q;
    off_next   = off_q;
    we_next    = mem_we;
    addr_next  = mem_addr;
    wstrb_next = mem_wstrb;
    wdata_next = mem_wdata;
    rdata_next = rdata;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (req_valid) begin
          state_next = DONE;
          if (align_illegal) begin
            cause_next = CAUSE_ILLEGAL;
          end else if (align_misaligned) begin
            cause_next = CAUSE_MISALIGN;
          end else begin
            cause_next = CAUSE_NONE;
            f3_next    = req_funct3;
            off_next   = req_addr[1:0];
            we_next    = req_we;
            addr_next  = {req_addr[XLEN-1:2], 2'b00};
            wstrb_next = align_wstrb;
            wdata_next = align_wdata;
            state_next = BUS;
          end
        end
      end
      BUS: begin
        if (mem_ready) begin
          if (!mem_we) rdata_next = align_rdata;
          cnt_next   = '0;
          state_next = DONE;
        end else if (cnt == WAIT_LAST) begin
          // Last permitted wait cycle expired: abandon the access.
          rdata_next = '0;
          cause_next = CAUSE_TIMEOUT;
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a scoreboard queue and a
// configurable-latency memory responder.
module tb_load_store_unit;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memword;
    int          delay;
    logic [1:0]  cause;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic [31:0] bwdata;
    int          lat;
    int          vcyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_cause;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int   total = 0;
  int   bad = 0;
  int   bus_wait = 0;
  int   ready_delay = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory answers after ready_delay cycles of a pending request.
  always @(posedge clk) bus_wait <= (mem_valid && !mem_ready) ? bus_wait + 1 : 0;
  assign mem_ready = mem_valid && (bus_wait == ready_delay);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic checkIdleZero(input string p);
    checkOutput({p, "_stall"}, 32'(stall), 32'd0);
    checkOutput({p, "_done"}, 32'(done), 32'd0);
    checkOutput({p, "_fault"}, 32'(fault), 32'd0);
    checkOutput({p, "_cause"}, 32'(fault_cause), 32'd0);
    checkOutput({p, "_mvalid"}, 32'(mem_valid), 32'd0);
    checkOutput({p, "_mwe"}, 32'(mem_we), 32'd0);
    checkOutput({p, "_mwstrb"}, 32'(mem_wstrb), 32'd0);
    checkOutput({p, "_maddr"}, mem_addr, 32'd0);
    checkOutput({p, "_mwdata"}, mem_wdata, 32'd0);
    checkOutput({p, "_rdata"}, rdata, 32'd0);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    vec_t        e;
    int          cycles, vcyc;
    bit          seen_done, stall_ok, stable, stall_at_done;
    logic [31:0] a0, d0;
    logic [3:0]  s0;
    logic        we0;
    string       p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    mem_rdata = v.memword; ready_delay = v.delay;
    exp_q.push_back(v);
    #1 checkOutput({p, "_stall_req"}, 32'(stall), 32'd1);
    cycles = 1; vcyc = 0; seen_done = 0; stall_ok = 1; stable = 1; stall_at_done = 1;
    a0 = '0; d0 = '0; s0 = '0; we0 = 1'b0;
    while (!seen_done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (mem_valid) begin
        if (vcyc == 0) begin
          a0 = mem_addr; d0 = mem_wdata; s0 = mem_wstrb; we0 = mem_we;
        end else if (a0 !== mem_addr || d0 !== mem_wdata || s0 !== mem_wstrb || we0 !== mem_we) begin
          stable = 0;
        end
        vcyc++;
      end
      if (done) begin
        seen_done = 1;
        stall_at_done = stall;
      end else if (!stall) begin
        stall_ok = 0;
      end
    end
    req_valid = 1'b0;
    e = exp_q.pop_front();
    if (!seen_done) begin
      total++; bad++;
      $display("[TB] FAIL %s_done_wait: got no done in %0d cycles want done", p, cycles);
      return;
    end
    checkOutput({p, "_latency"}, 32'(cycles), 32'(e.lat));
    checkOutput({p, "_stall_wait"}, 32'(stall_ok), 32'd1);
    checkOutput({p, "_stall_done"}, 32'(stall_at_done), 32'd0);
    checkOutput({p, "_fault"}, 32'(fault), 32'(e.cause != 2'b00));
    checkOutput({p, "_cause"}, 32'(fault_cause), 32'(e.cause));
    checkOutput({p, "_rdata"}, rdata, e.rdata);
    checkOutput({p, "_valid_cycles"}, 32'(vcyc), 32'(e.vcyc));
    if (e.vcyc > 0) begin
      checkOutput({p, "_maddr"}, a0, {e.addr[31:2], 2'b00});
      checkOutput({p, "_mwe"}, 32'(we0), 32'(e.we));
      checkOutput({p, "_mwstrb"}, 32'(s0), 32'(e.wstrb));
      checkOutput({p, "_stable"}, 32'(stable), 32'd1);
      if (e.we) checkOutput({p, "_mwdata"}, d0, e.bwdata);
    end
  endtask

  initial begin
    // we f3 addr wdata memword delay | cause rdata wstrb bus_wdata latency valid_cycles
    vecs.push_back('{1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2'd0, 32'hDEADBEEF, 4'b0000, 32'h0, 3, 1});
    vecs.push_back('{1'b0, 3'd0, 32'h203, 32'h0, 32'h80FFFFFF, 0, 2'd0, 32'hFFFFFF80, 4'b0000, 32'h0, 3, 1});
    vecs.push_back('{1'b0, 3'd4, 32'h203, 32'h0, 32'h80FFFFFF, 0, 2'd0, 32'h00000080, 4'b0000, 32'h0, 3, 1});
    vecs.push_back('{1'b0, 3'd5, 32'h202, 32'h0, 32'h80FFFFFF, 0, 2'd0, 32'h000080FF, 4'b0000, 32'h0, 3, 1});
    vecs.push_back('{1'b0, 3'd1, 32'h202, 32'h0, 32'h80FFFFFF, 0, 2'd0, 32'hFFFF80FF, 4'b0000, 32'h0, 3, 1});
    vecs.push_back('{1'b1, 3'd0, 32'h101, 32'h000000AB, 32'h11111111, 0, 2'd0, 32'hFFFF80FF, 4'b0010, 32'hABABABAB, 3, 1});
    vecs.push_back('{1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0, 2, 2'd0, 32'hFFFF80FF, 4'b1100, 32'h12341234, 5, 3});
    vecs.push_back('{1'b1, 3'd2, 32'h104, 32'hCAFEF00D, 32'h0, 0, 2'd0, 32'hFFFF80FF, 4'b1111, 32'hCAFEF00D, 3, 1});
    vecs.push_back('{1'b0, 3'd2, 32'h102, 32'h0, 32'h12345678, 0, 2'd1, 32'hFFFF80FF, 4'b0000, 32'h0, 2, 0});
    vecs.push_back('{1'b0, 3'd3, 32'h100, 32'h0, 32'h12345678, 0, 2'd3, 32'hFFFF80FF, 4'b0000, 32'h0, 2, 0});
    vecs.push_back('{1'b1, 3'd1, 32'h103, 32'h00005555, 32'h0, 0, 2'd1, 32'hFFFF80FF, 4'b0000, 32'h0, 2, 0});
    vecs.push_back('{1'b1, 3'd4, 32'h100, 32'h00005555, 32'h0, 0, 2'd3, 32'hFFFF80FF, 4'b0000, 32'h0, 2, 0});
    vecs.push_back('{1'b0, 3'd0, 32'h001, 32'h0, 32'h00007F00, 1, 2'd0, 32'h0000007F, 4'b0000, 32'h0, 4, 2});
    vecs.push_back('{1'b0, 3'd2, 32'h010, 32'h0, 32'hFFFFFFFF, 99, 2'd2, 32'h00000000, 4'b0000, 32'h0, 6, 4});
    vecs.push_back('{1'b0, 3'd5, 32'h200, 32'h0, 32'h1234ABCD, 3, 2'd0, 32'h0000ABCD, 4'b0000, 32'h0, 6, 4});
    vecs.push_back('{1'b1, 3'd7, 32'h101, 32'h0, 32'h0, 0, 2'd3, 32'h0000ABCD, 4'b0000, 32'h0, 2, 0});
    vecs.push_back('{1'b0, 3'd2, 32'h300, 32'h0, 32'h0BADF00D, 0, 2'd0, 32'h0BADF00D, 4'b0000, 32'h0, 3, 1});

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    checkIdleZero("reset");
    reset = 1'b0;

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Reset during the second cycle of a stuck bus access.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h400; ready_delay = 99;
    @(negedge clk);
    checkOutput("rst_bus1_valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    checkOutput("rst_bus2_valid", 32'(mem_valid), 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checkIdleZero("midreset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    applyStimulus(100, '{1'b0, 3'd2, 32'h500, 32'h0, 32'hA5A5A5A5, 0, 2'd0, 32'hA5A5A5A5, 4'b0000, 32'h0, 3, 1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle datapath's ALU.
- Consumes ALUResult (address) and WriteData (store data), and returns ReadData to the result mux.
- Converts byte/halfword/word loads and stores into word-aligned memory bus transactions with a valid/ready handshake.
- Stalls the datapath until each access completes, faults, or times out.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- MAX_WAIT, 16, bus cycles to wait for mem_ready before a timeout fault; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  the current instruction is a load or store; held high while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address (ALUResult).
- req_wdata  in  32  store data (WriteData), right-justified.
- stall  out  1  freeze the PC and suppress the regfile write.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load data (ReadData).
- fault  out  1  one-cycle pulse, coincident with done.
- fault_cause  out  2  01 misaligned, 10 bus timeout, 11 illegal funct3; 00 when no fault.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus accept/complete.
- mem_we  out  1  bus write.
- mem_addr  out  32  word address, bits [1:0] = 0.
- mem_wstrb  out  4  byte-lane enables; 0000 for reads.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid on the cycle mem_ready=1.

Behaviour:
- Reset values:
  - state IDLE.
  - mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
  - rdata=0, done=0, fault=0, fault_cause=00.
  - wait counter 0.
- State machine:
  - IDLE: on req_valid, decode the request.
    - Illegal funct3 (loads 3/6/7; stores 3..7) -> DONE with cause 11.
    - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) -> DONE with cause 01.
    - Otherwise latch mem_addr={addr[31:2],00}, mem_we, mem_wstrb, mem_wdata, addr[1:0] and funct3 -> BUS.
    - Faulting requests issue no bus transaction and write no memory.
  - BUS: mem_valid=1 with all bus outputs stable. The counter increments each cycle mem_ready=0.
    - mem_ready=1: a load captures the extended mem_rdata into rdata; -> DONE with cause 00.
    - Counter reaches MAX_WAIT with mem_ready=0: drop mem_valid; rdata<=0; -> DONE with cause 10.
  - DONE: done=1; fault=(cause!=00); fault_cause=latched cause; mem_valid=0. -> IDLE unconditionally.
- stall = req_valid && state!=DONE, combinational.
  - Minimum latency is 3 cycles (IDLE, BUS, DONE) for zero-wait memory.
  - A fault completes in 2 cycles.
  - Back-to-back memory instructions incur the DONE->IDLE cycle between them.
- Store lanes, with o = addr[1:0]:
  - SB: wstrb = 0001<<o; wdata = {4{byte}}.
  - SH: wstrb = 0011<<o; wdata = {2{half}}.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000.
- Load extraction: shift mem_rdata right by 8*o, then:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- rdata holds its value until the next completing load or fault.
  - Stores and faults do not update it, except a timeout, which writes 0.
- req_valid dropping while in BUS is a protocol violation. The transaction still completes; behaviour is undefined beyond that.
- Reset in any state takes effect at the next edge. mem_valid drops immediately and the in-flight bus request is abandoned; memory must tolerate this.
- mem_ready while in IDLE or DONE is ignored.

Decomposition:
- lsu_pkg:
  - state enum {IDLE, BUS, DONE}.
  - funct3 constants F3_B/H/W/BU/HU.
  - fault cause constants CAUSE_NONE/MISALIGN/TIMEOUT/ILLEGAL.
- Sub-module lsu_align (purely combinational):
  - funct3 + offset + wdata -> wstrb/wdata.
  - funct3 + offset + mem_rdata -> extended rdata.
  - Also flags misaligned/illegal.
- The FSM and wait counter stay in load_store_unit.

Test Plan:
- LW addr 0x100, mem_ready=1 on the first BUS cycle, mem_rdata=0xDEADBEEF:
  - mem_addr=0x100, wstrb=0000.
  - done in cycle 3; rdata=0xDEADBEEF; stall high for 2 cycles.
- LB addr 0x203 with rdata 0x80FFFFFF -> rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr 0x202 -> 0x000080FF.
- SB addr 0x101, wdata 0x000000AB -> mem_addr=0x100, wstrb=0010, mem_wdata=0xABABABAB, mem_we=1. SH addr 0x102 wdata 0x1234 -> wstrb=1100.
- LW addr 0x102 -> no mem_valid ever; done+fault on cycle 2; cause=01; rdata unchanged. funct3=3 load -> cause=11.
- mem_ready held 0, MAX_WAIT=4 -> mem_valid high exactly 4 cycles, then done/fault with cause=10 and rdata=0.
- Reset asserted on the 2nd BUS cycle -> next cycle state=IDLE, mem_valid=0, stall=0 once req_valid drops, and all outputs at reset values.
